// File: rtl/t5_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : t5_pkg
//  Brief    : Shared constants for the t5 Wishbone arbiter (state codes,
//             bus field widths, default timeout limit).
//  Revision : 1.0 - initial release
// ============================================================================
package t5_pkg;

    localparam int unsigned      c_AW      = 30;
    localparam int unsigned      c_SEL     = 4;
    localparam logic [7:0]       c_TOUT    = 8'd255;

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_IBUS = 2'd1;
    localparam logic [1:0]       c_ST_DBUS = 2'd2;

    localparam logic [c_SEL-1:0] c_SEL_ALL = '1;

endpackage
`default_nettype wire

// File: rtl/t5_wbarb_tmr.sv
`default_nettype none
// ============================================================================
//  Module   : t5_wbarb_tmr
//  Brief    : Bus-cycle timeout counter; built only with T5_WBARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef T5_WBARB_TIMEOUT_EN
module t5_wbarb_tmr
    import t5_pkg::*;
#(
    parameter logic [7:0] TOUT = c_TOUT
) (
    input  logic sclk,
    input  logic srst,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expired
);

    logic [7:0] r_count;

    // Saturates at the limit; the next grant edge clears it.
    always_ff @(posedge sclk) begin
        if (srst) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_run && !i_ack && (r_count != TOUT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_run & ~i_ack & (r_count == TOUT);

endmodule
`endif
`default_nettype wire

// File: rtl/t5_wbarb.sv
`default_nettype none
// ============================================================================
//  Module   : t5_wbarb
//  Brief    : Two-requester Wishbone arbiter (fetch/data), data has priority.
//             Optional bus timeout enabled by macro T5_WBARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module t5_wbarb
    import t5_pkg::*;
#(
    parameter int unsigned AW   = c_AW,
    parameter logic [7:0]  TOUT = c_TOUT
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             iwb_stb,
    input  logic [AW-1:0]    iwb_adr,
    output logic [31:0]      iwb_dat,
    output logic             iwb_ack,
    input  logic             dwb_stb,
    input  logic             dwb_we,
    input  logic [c_SEL-1:0] dwb_sel,
    input  logic [AW-1:0]    dwb_adr,
    input  logic [31:0]      dwb_dto,
    output logic [31:0]      dwb_dti,
    output logic             dwb_ack,
    output logic             xwb_cyc,
    output logic             xwb_stb,
    output logic             xwb_we,
    output logic [c_SEL-1:0] xwb_sel,
    output logic [AW-1:0]    xwb_adr,
    output logic [31:0]      xwb_dto,
    input  logic [31:0]      xwb_dti,
    input  logic             xwb_ack,
    output logic             xwb_err
);

    logic [1:0]       r_state;
    logic             r_xwb_cyc;
    logic             r_xwb_stb;
    logic             r_xwb_we;
    logic [c_SEL-1:0] r_xwb_sel;
    logic [AW-1:0]    r_xwb_adr;
    logic [31:0]      r_xwb_dto;

    logic             w_in_ibus;
    logic             w_in_dbus;
    logic             w_grant_i;
    logic             w_grant_d;
    logic             w_release;
    logic             w_abort;
    logic [31:0]      w_rdata;

    assign w_in_ibus = (r_state == c_ST_IBUS);
    assign w_in_dbus = (r_state == c_ST_DBUS);

`ifdef T5_WBARB_TIMEOUT_EN
    t5_wbarb_tmr #(
        .TOUT      (TOUT)
    ) u_tmr (
        .sclk      (sclk),
        .srst      (srst),
        .i_clr     (w_grant_i | w_grant_d),
        .i_run     (w_in_ibus | w_in_dbus),
        .i_ack     (xwb_ack),
        .o_expired (w_abort)
    );
`else
    logic w_unused_tout;
    assign w_unused_tout = ^TOUT;
    assign w_abort       = 1'b0;
`endif

    // The requester finishing on this edge is never re-granted here.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_release = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_grant_d = dwb_stb;
                w_grant_i = ~dwb_stb & iwb_stb;
            end
            c_ST_IBUS: begin
                if (xwb_ack) begin
                    w_grant_d = dwb_stb;
                    w_release = ~dwb_stb;
                end else begin
                    w_release = w_abort;
                end
            end
            c_ST_DBUS: begin
                if (xwb_ack) begin
                    w_grant_i = iwb_stb;
                    w_release = ~iwb_stb;
                end else begin
                    w_release = w_abort;
                end
            end
            default: begin
                w_release = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_state   <= c_ST_IDLE;
            r_xwb_cyc <= 1'b0;
            r_xwb_stb <= 1'b0;
            r_xwb_we  <= 1'b0;
            r_xwb_sel <= '0;
            r_xwb_adr <= '0;
            r_xwb_dto <= '0;
        end else if (w_grant_d) begin
            r_state   <= c_ST_DBUS;
            r_xwb_cyc <= 1'b1;
            r_xwb_stb <= 1'b1;
            r_xwb_we  <= dwb_we;
            r_xwb_sel <= dwb_sel;
            r_xwb_adr <= dwb_adr;
            r_xwb_dto <= dwb_dto;
        end else if (w_grant_i) begin
            r_state   <= c_ST_IBUS;
            r_xwb_cyc <= 1'b1;
            r_xwb_stb <= 1'b1;
            r_xwb_we  <= 1'b0;
            r_xwb_sel <= c_SEL_ALL;
            r_xwb_adr <= iwb_adr;
            r_xwb_dto <= '0;
        end else if (w_release) begin
            r_state   <= c_ST_IDLE;
            r_xwb_cyc <= 1'b0;
            r_xwb_stb <= 1'b0;
        end
    end

    // An aborted cycle returns zero data to the requester.
    assign w_rdata = w_abort ? 32'h0 : xwb_dti;

    assign iwb_dat = w_rdata;
    assign dwb_dti = w_rdata;
    assign iwb_ack = w_in_ibus & (xwb_ack | w_abort);
    assign dwb_ack = w_in_dbus & (xwb_ack | w_abort);
    assign xwb_err = w_abort;

    assign xwb_cyc = r_xwb_cyc;
    assign xwb_stb = r_xwb_stb;
    assign xwb_we  = r_xwb_we;
    assign xwb_sel = r_xwb_sel;
    assign xwb_adr = r_xwb_adr;
    assign xwb_dto = r_xwb_dto;

endmodule
`default_nettype wire

// File: tb/tb_t5_wbarb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t5_wbarb
//  Brief    : Directed vector bench for t5_wbarb (T5_WBARB_TIMEOUT_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_t5_wbarb;

`ifdef T5_WBARB_TIMEOUT_EN
    localparam logic [7:0] c_TB_TOUT = 8'd4;
`else
    localparam logic [7:0] c_TB_TOUT = 8'd255;
`endif

    logic        sclk = 1'b0;
    logic        srst;
    logic        iwb_stb;
    logic [29:0] iwb_adr;
    logic [31:0] iwb_dat;
    logic        iwb_ack;
    logic        dwb_stb;
    logic        dwb_we;
    logic [3:0]  dwb_sel;
    logic [29:0] dwb_adr;
    logic [31:0] dwb_dto;
    logic [31:0] dwb_dti;
    logic        dwb_ack;
    logic        xwb_cyc;
    logic        xwb_stb;
    logic        xwb_we;
    logic [3:0]  xwb_sel;
    logic [29:0] xwb_adr;
    logic [31:0] xwb_dto;
    logic [31:0] xwb_dti;
    logic        xwb_ack;
    logic        xwb_err;

    int checks   = 0;
    int failures = 0;

    always #5 sclk = ~sclk;

    t5_wbarb #(
        .AW      (30),
        .TOUT    (c_TB_TOUT)
    ) dut (
        .sclk    (sclk),
        .srst    (srst),
        .iwb_stb (iwb_stb),
        .iwb_adr (iwb_adr),
        .iwb_dat (iwb_dat),
        .iwb_ack (iwb_ack),
        .dwb_stb (dwb_stb),
        .dwb_we  (dwb_we),
        .dwb_sel (dwb_sel),
        .dwb_adr (dwb_adr),
        .dwb_dto (dwb_dto),
        .dwb_dti (dwb_dti),
        .dwb_ack (dwb_ack),
        .xwb_cyc (xwb_cyc),
        .xwb_stb (xwb_stb),
        .xwb_we  (xwb_we),
        .xwb_sel (xwb_sel),
        .xwb_adr (xwb_adr),
        .xwb_dto (xwb_dto),
        .xwb_dti (xwb_dti),
        .xwb_ack (xwb_ack),
        .xwb_err (xwb_err)
    );

    typedef struct {
        logic        srst;
        logic        istb;
        logic [29:0] iadr;
        logic        dstb;
        logic        dwe;
        logic [3:0]  dsel;
        logic [29:0] dadr;
        logic [31:0] ddto;
        logic [31:0] xdti;
        logic        xack;
        logic        e_cyc;
        logic        e_stb;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [29:0] e_adr;
        logic [31:0] e_dto;
        logic        e_iack;
        logic        e_dack;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rs, input logic is, input logic [29:0] ia,
                       input logic ds, input logic dw, input logic [3:0] dl,
                       input logic [29:0] da, input logic [31:0] dd,
                       input logic [31:0] xd, input logic xa,
                       input logic ec, input logic es, input logic ew,
                       input logic [3:0] el, input logic [29:0] ea,
                       input logic [31:0] ed, input logic ei, input logic edk);
        vec_t v;
        v.srst = rs; v.istb = is; v.iadr = ia; v.dstb = ds; v.dwe = dw;
        v.dsel = dl; v.dadr = da; v.ddto = dd; v.xdti = xd; v.xack = xa;
        v.e_cyc = ec; v.e_stb = es; v.e_we = ew; v.e_sel = el; v.e_adr = ea;
        v.e_dto = ed; v.e_iack = ei; v.e_dack = edk;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic idle_inputs();
        srst = 1'b0; iwb_stb = 1'b0; iwb_adr = '0; dwb_stb = 1'b0; dwb_we = 1'b0;
        dwb_sel = '0; dwb_adr = '0; dwb_dto = '0; xwb_dti = '0; xwb_ack = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        idle_inputs();
        srst = 1'b1;
        step();
        step();

        //  rs  is  iadr      ds  we  sel   dadr      ddto          xdti          xa  | cyc stb we sel   adr       dto           iack dack
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 0, 4'h0, 30'h0,   32'h0,        0, 0); // reset state
        add(0, 1, 30'h100, 0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 0, 4'h0, 30'h0,   32'h0,        0, 0);
        add(0, 1, 30'h100, 0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  1, 1, 0, 4'hF, 30'h100, 32'h0,        0, 0);
        add(0, 1, 30'h100, 0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  1, 1, 0, 4'hF, 30'h100, 32'h0,        0, 0);
        add(0, 1, 30'h100, 0, 0, 4'h0, 30'h0,   32'h0,        32'h13,       1,  1, 1, 0, 4'hF, 30'h100, 32'h0,        1, 0);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 0, 4'hF, 30'h100, 32'h0,        0, 0);
        // simultaneous requests: data first, then fetch with cyc held
        add(0, 1, 30'h200, 1, 1, 4'h3, 30'h300, 32'hDEADBEEF, 32'h0,        0,  0, 0, 0, 4'hF, 30'h100, 32'h0,        0, 0);
        add(0, 1, 30'h200, 1, 1, 4'h3, 30'h300, 32'hDEADBEEF, 32'h0,        0,  1, 1, 1, 4'h3, 30'h300, 32'hDEADBEEF, 0, 0);
        add(0, 1, 30'h200, 1, 1, 4'h3, 30'h300, 32'hDEADBEEF, 32'h55,       1,  1, 1, 1, 4'h3, 30'h300, 32'hDEADBEEF, 0, 1);
        add(0, 1, 30'h200, 0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  1, 1, 0, 4'hF, 30'h200, 32'h0,        0, 0);
        // fetch held across its ack: one-cycle gap then re-grant
        add(0, 1, 30'h200, 0, 0, 4'h0, 30'h0,   32'h0,        32'h77,       1,  1, 1, 0, 4'hF, 30'h200, 32'h0,        1, 0);
        add(0, 1, 30'h204, 0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 0, 4'hF, 30'h200, 32'h0,        0, 0);
        add(0, 1, 30'h204, 0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  1, 1, 0, 4'hF, 30'h204, 32'h0,        0, 0);
        add(0, 1, 30'h204, 0, 0, 4'h0, 30'h0,   32'h0,        32'h99,       1,  1, 1, 0, 4'hF, 30'h204, 32'h0,        1, 0);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 0, 4'hF, 30'h204, 32'h0,        0, 0);
        // reset during a data transfer, then stray acks while idle
        add(0, 0, 30'h0,   1, 0, 4'hF, 30'h3C0, 32'h0,        32'h0,        0,  0, 0, 0, 4'hF, 30'h204, 32'h0,        0, 0);
        add(0, 0, 30'h0,   1, 0, 4'hF, 30'h3C0, 32'h0,        32'h0,        0,  1, 1, 0, 4'hF, 30'h3C0, 32'h0,        0, 0);
        add(1, 0, 30'h0,   1, 0, 4'hF, 30'h3C0, 32'h0,        32'h0,        0,  1, 1, 0, 4'hF, 30'h3C0, 32'h0,        0, 0);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'hAB,       1,  0, 0, 0, 4'h0, 30'h0,   32'h0,        0, 0);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'hCD,       1,  0, 0, 0, 4'h0, 30'h0,   32'h0,        0, 0);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 0, 4'h0, 30'h0,   32'h0,        0, 0);
        // requester drops stb mid-transfer: cycle still completes and acks
        add(0, 0, 30'h0,   1, 1, 4'hC, 30'h10,  32'h12345678, 32'h0,        0,  0, 0, 0, 4'h0, 30'h0,   32'h0,        0, 0);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  1, 1, 1, 4'hC, 30'h10,  32'h12345678, 0, 0);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        1,  1, 1, 1, 4'hC, 30'h10,  32'h12345678, 0, 1);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 1, 4'hC, 30'h10,  32'h12345678, 0, 0);
        // fetch granted, data arrives during it: handover to data on ack
        add(0, 1, 30'h50,  0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 1, 4'hC, 30'h10,  32'h12345678, 0, 0);
        add(0, 1, 30'h50,  1, 0, 4'h1, 30'h60,  32'hAA,       32'h0,        0,  1, 1, 0, 4'hF, 30'h50,  32'h0,        0, 0);
        add(0, 1, 30'h50,  1, 0, 4'h1, 30'h60,  32'hAA,       32'h1111,     1,  1, 1, 0, 4'hF, 30'h50,  32'h0,        1, 0);
        add(0, 0, 30'h0,   1, 0, 4'h1, 30'h60,  32'hAA,       32'h0,        0,  1, 1, 0, 4'h1, 30'h60,  32'hAA,       0, 0);
        add(0, 0, 30'h0,   1, 0, 4'h1, 30'h60,  32'hAA,       32'h2222,     1,  1, 1, 0, 4'h1, 30'h60,  32'hAA,       0, 1);
        add(0, 0, 30'h0,   0, 0, 4'h0, 30'h0,   32'h0,        32'h0,        0,  0, 0, 0, 4'h1, 30'h60,  32'hAA,       0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            srst    = vecs[i].srst;
            iwb_stb = vecs[i].istb;
            iwb_adr = vecs[i].iadr;
            dwb_stb = vecs[i].dstb;
            dwb_we  = vecs[i].dwe;
            dwb_sel = vecs[i].dsel;
            dwb_adr = vecs[i].dadr;
            dwb_dto = vecs[i].ddto;
            xwb_dti = vecs[i].xdti;
            xwb_ack = vecs[i].xack;
            #1;
            checks++;
            if (xwb_cyc !== vecs[i].e_cyc || xwb_stb !== vecs[i].e_stb ||
                xwb_we !== vecs[i].e_we || xwb_sel !== vecs[i].e_sel ||
                xwb_adr !== vecs[i].e_adr || xwb_dto !== vecs[i].e_dto ||
                iwb_ack !== vecs[i].e_iack || dwb_ack !== vecs[i].e_dack ||
                iwb_dat !== vecs[i].xdti || dwb_dti !== vecs[i].xdti ||
                xwb_err !== 1'b0) begin
                failures++;
                $display("FAIL vec%0d: got cyc=%b stb=%b we=%b sel=%h adr=%h dto=%h iack=%b dack=%b idat=%h ddat=%h err=%b exp cyc=%b stb=%b we=%b sel=%h adr=%h dto=%h iack=%b dack=%b dat=%h err=0",
                         i, xwb_cyc, xwb_stb, xwb_we, xwb_sel, xwb_adr, xwb_dto, iwb_ack, dwb_ack,
                         iwb_dat, dwb_dti, xwb_err, vecs[i].e_cyc, vecs[i].e_stb, vecs[i].e_we,
                         vecs[i].e_sel, vecs[i].e_adr, vecs[i].e_dto, vecs[i].e_iack, vecs[i].e_dack,
                         vecs[i].xdti);
            end
            step();
        end

        // Unacknowledged data read
        idle_inputs();
        dwb_stb = 1'b1;
        dwb_adr = 30'h80;
        dwb_sel = 4'hF;
        xwb_dti = 32'hFFFFFFFF;
        step();
`ifdef T5_WBARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            check_bit($sformatf("tout_wait%0d_ack", k), dwb_ack, 1'b0);
            check_bit($sformatf("tout_wait%0d_err", k), xwb_err, 1'b0);
            step();
        end
        check_bit("tout_abort_ack", dwb_ack, 1'b1);
        check_bit("tout_abort_iack", iwb_ack, 1'b0);
        check_bit("tout_abort_err", xwb_err, 1'b1);
        check_word("tout_abort_dti", dwb_dti, 32'h0);
        check_bit("tout_abort_cyc", xwb_cyc, 1'b1);
        step();
        check_bit("tout_after_cyc", xwb_cyc, 1'b0);
        check_bit("tout_after_err", xwb_err, 1'b0);
        check_bit("tout_after_ack", dwb_ack, 1'b0);
`else
        for (int k = 0; k < 10; k++) begin
            check_bit($sformatf("wait%0d_cyc", k), xwb_cyc & xwb_stb, 1'b1);
            check_bit($sformatf("wait%0d_ack", k), dwb_ack, 1'b0);
            check_bit($sformatf("wait%0d_err", k), xwb_err, 1'b0);
            step();
        end
        srst = 1'b1;
        step();
        srst    = 1'b0;
        dwb_stb = 1'b0;
        check_bit("wait_reset_cyc", xwb_cyc, 1'b0);
        check_bit("wait_reset_ack", dwb_ack, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t5_wbarb.md
Name: t5_wbarb

Overview:
- Two-requester Wishbone arbiter.
- Shares one external bus master port between the instruction-fetch port (iwb) and the load/store port (dwb) of the t5 core.
- Sits between the core's fetch/execute stages and the system bus; owns cycle sequencing, grant hold and response routing.
- Data port has priority; fetch is guaranteed the next slot after any data transfer.

Parameters:
- AW, 30, word-address width (byte address bits [31:2]).
- TOUT, 255, bus-timeout limit in cycles (used only with the optional feature); 8-bit counter.

Ports:
- sclk  in  1  system clock, rising edge.
- srst  in  1  synchronous active-high reset.
- iwb_stb  in  1  fetch request; held high until iwb_ack.
- iwb_adr  in  AW  fetch word address.
- iwb_dat  out  32  fetch read data; valid when iwb_ack.
- iwb_ack  out  1  fetch transfer done.
- dwb_stb  in  1  data request; held high until dwb_ack.
- dwb_we  in  1  data write enable.
- dwb_sel  in  4  byte lanes.
- dwb_adr  in  AW  data word address.
- dwb_dto  in  32  write data.
- dwb_dti  out  32  read data; valid when dwb_ack.
- dwb_ack  out  1  data transfer done.
- xwb_cyc, xwb_stb  out  1  external cycle/strobe.
- xwb_we  out  1  external write enable.
- xwb_sel  out  4  external byte lanes.
- xwb_adr  out  AW  external address.
- xwb_dto  out  32  external write data.
- xwb_dti  in  32  external read data.
- xwb_ack  in  1  external acknowledge.
- xwb_err  out  1  timeout pulse (0 when feature disabled).

Behaviour:
- Single clock sclk; reset srst is synchronous and active-high.
- FSM states: IDLE, IBUS, DBUS. On reset: IDLE.
- Reset values: all xwb_* = 0; iwb_ack = dwb_ack = 0; xwb_err = 0; timeout counter = 0.
- IDLE:
  - dwb_stb high -> DBUS (dwb_stb wins over iwb_stb when both high).
  - else iwb_stb high -> IBUS.
  - else stay in IDLE.
- Grant edge:
  - Latch the granted requester's adr/we/sel/dto into xwb_* registers.
  - Set xwb_cyc = xwb_stb = 1.
  - For fetch: xwb_we = 0, xwb_sel = 4'hF.
  - Latency: request high in cycle N -> xwb_stb high in cycle N+1.
- Hold: xwb_* remain constant while in IBUS/DBUS until xwb_ack is seen.
- Response routing (combinational):
  - iwb_ack = xwb_ack & IBUS.
  - dwb_ack = xwb_ack & DBUS.
  - iwb_dat = dwb_dti = xwb_dti.
- Ack edge, IBUS: next state is DBUS if dwb_stb, else IDLE.
- Ack edge, DBUS: next state is IBUS if iwb_stb, else IDLE.
- The requester that just completed is never re-granted on its own ack edge; its stb in that cycle belongs to the finished transfer.
- Back-to-back handover to the other port: xwb_cyc stays high, xwb_stb stays high, xwb_* reload on the same edge. No idle gap.
- Return to IDLE: xwb_cyc and xwb_stb drop on the ack edge.
- Requester drops stb mid-transfer: protocol violation. The arbiter still completes the latched cycle, and the ack pulse is routed regardless.
- srst mid-transfer: xwb_cyc and xwb_stb go to 0 on the next edge, state returns to IDLE, and no ack is generated.
- xwb_ack while in IDLE: ignored; no requester ack is produced.

Optional Feature:
- Macro: T5_WBARB_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on every grant edge and increments each cycle in IBUS/DBUS without xwb_ack.
  - When the count reaches TOUT with no ack: the cycle aborts (xwb_cyc/stb = 0 next edge) and the FSM goes to IDLE.
  - In the abort cycle, the granted requester's ack pulses once with read data 32'h0, and xwb_err pulses for 1 cycle.
- Undefined: no counter; xwb_err tied 0; a transfer waits indefinitely for xwb_ack.

Decomposition:
- Shared package (t5_pkg):
  - FSM state encoding: IDLE = 2'd0, IBUS = 2'd1, DBUS = 2'd2.
  - Wishbone field widths: AW, SEL = 4.
  - Default TOUT constant.
- One sub-module, t5_wbarb_tmr: the timeout counter. Instantiated only under T5_WBARB_TIMEOUT_EN.

Test Plan:
- Fetch only: iwb_stb = 1, iwb_adr = 30'h100.
  - -> xwb_stb next cycle with xwb_adr = 30'h100, xwb_we = 0, xwb_sel = F.
  - Slave acks 2 cycles later with xwb_dti = 32'h00000013 -> iwb_ack 1 cycle with iwb_dat = 32'h13, then IDLE.
- Simultaneous requests: iwb_stb and dwb_stb rise together, dwb_we = 1, dwb_sel = 4'h3.
  - -> DBUS granted first.
  - On its ack, xwb_adr reloads to the fetch address with xwb_cyc held high, then IBUS.
- Repeated fetch: iwb_stb held high across its ack with no data request.
  - -> xwb_cyc drops for exactly 1 cycle, then fetch is re-granted.
- Reset mid-transfer: srst asserted while in DBUS before ack.
  - -> next edge xwb_cyc = 0, dwb_ack never pulses, FSM in IDLE.
- Stray ack: xwb_ack pulsed while IDLE.
  - -> iwb_ack = dwb_ack = 0, state unchanged.
- With T5_WBARB_TIMEOUT_EN, TOUT = 4: slave never acks a dwb read.
  - -> after 4 waiting cycles, dwb_ack pulses with dwb_dti = 0, xwb_err pulses once, and the arbiter returns to IDLE.
